// File: rtl/seg7_scan_display_if.sv
// seg7_scan_display_if: value/button inputs and seven-segment outputs of the scan display
interface seg7_scan_display_if;
    logic [31:0] value_in;
    logic        value_valid;
    logic        page_btn;
    logic [6:0]  seg;
    logic [3:0]  digit;
    logic        dp;
    logic        page_out;

    modport master (
        output value_in, value_valid, page_btn,
        input  seg, digit, dp, page_out
    );

    modport slave (
        input  value_in, value_valid, page_btn,
        output seg, digit, dp, page_out
    );
endinterface

// File: rtl/seg7_scan_display.sv
// seg7_scan_display: four-digit multiplexed hex display of a 32-bit snapshot, button-selected half
module seg7_scan_display #(
    parameter int REFRESH_DIV     = 50000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input logic               CLK_IN,
    input logic               GLOBALRESET,
    seg7_scan_display_if.slave bus
);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic {STABLE0, STABLE1} db_state_t;

    logic [31:0]   snapshot;
    logic [RW-1:0] ref_cnt;
    logic [1:0]    idx;
    logic          page;
    logic          sync1, sync2;
    db_state_t     state_q, state_d;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    logic          rise;
    logic [3:0]    nibble;
    logic [6:0]    seg_q;
    logic [3:0]    digit_q;
    logic          dp_q;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    always_ff @(posedge CLK_IN or posedge GLOBALRESET) begin
        if (GLOBALRESET) begin
            snapshot <= '0;
        end else if (bus.value_valid) begin
            snapshot <= bus.value_in;
        end
    end

    always_ff @(posedge CLK_IN or posedge GLOBALRESET) begin
        if (GLOBALRESET) begin
            ref_cnt <= '0;
            idx     <= '0;
        end else if (ref_cnt == RW'(REFRESH_DIV - 1)) begin
            ref_cnt <= '0;
            idx     <= idx + 2'd1;
        end else begin
            ref_cnt <= ref_cnt + RW'(1);
        end
    end

    always_ff @(posedge CLK_IN or posedge GLOBALRESET) begin
        if (GLOBALRESET) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            state_q  <= STABLE0;
            db_cnt_q <= '0;
            page     <= 1'b0;
        end else begin
            sync1    <= bus.page_btn;
            sync2    <= sync1;
            state_q  <= state_d;
            db_cnt_q <= db_cnt_d;
            page     <= page ^ rise;
        end
    end

    // A level is accepted only after it disagrees with the state for DEBOUNCE_CYCLES+1 samples in a row
    always_comb begin
        state_d  = state_q;
        db_cnt_d = '0;
        rise     = 1'b0;
        if (sync2 != (state_q == STABLE1)) begin
            if (db_cnt_q == DW'(DEBOUNCE_CYCLES)) begin
                state_d = (state_q == STABLE0) ? STABLE1 : STABLE0;
                rise    = (state_q == STABLE0);
            end else begin
                db_cnt_d = db_cnt_q + DW'(1);
            end
        end
    end

    assign nibble = snapshot[{page, idx, 2'b00} +: 4];

    always_ff @(posedge CLK_IN or posedge GLOBALRESET) begin
        if (GLOBALRESET) begin
            seg_q   <= 7'b1000000;
            digit_q <= 4'b1110;
            dp_q    <= 1'b1;
        end else begin
            seg_q   <= hex7(nibble);
            digit_q <= ~(4'b0001 << idx);
            dp_q    <= ~((idx == 2'd3) && page);
        end
    end

    assign bus.seg      = seg_q;
    assign bus.digit    = digit_q;
    assign bus.dp       = dp_q;
    assign bus.page_out = page;
endmodule

// File: tb/tb_seg7_scan_display.sv
// tb_seg7_scan_display: randomized and directed stimulus against a cycle-indexed reference model
module tb_seg7_scan_display;
    localparam int R = 4;
    localparam int D = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    seg7_scan_display_if bus();

    seg7_scan_display #(.REFRESH_DIV(R), .DEBOUNCE_CYCLES(D)) dut (
        .CLK_IN(clk),
        .GLOBALRESET(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_pass = 0;

    logic [6:0] hex_tbl [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic [31:0] m_snap;
    logic        m_page;
    logic        m_state;
    int          k;
    bit          hist[$];
    logic [6:0]  exp_seg;
    logic [3:0]  exp_dig;
    logic        exp_dp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at edge %0d: got %h expected %h", tag, k, got, exp);
    endtask

    // Raw button level sampled at edge j after reset; nothing was pressed before edge 1
    function automatic bit samp(input int j);
        return (j >= 1) ? hist[j-1] : 1'b0;
    endfunction

    task automatic tick;
        int ip;
        bit flip;
        logic [3:0] nib;
        @(posedge clk);
        ip      = (k / R) % 4;
        nib     = m_snap[m_page*16 + ip*4 +: 4];
        exp_seg = hex_tbl[nib];
        exp_dig = ~(4'b0001 << ip);
        exp_dp  = !(ip == 3 && m_page);
        k++;
        if (bus.value_valid) m_snap = bus.value_in;
        hist.push_back(bus.page_btn);
        flip = 1'b1;
        for (int j = k - 2 - D; j <= k - 2; j++)
            if (samp(j) == m_state) flip = 1'b0;
        if (flip) begin
            m_state = ~m_state;
            if (m_state) m_page = ~m_page;
        end
        #1;
        check("seg", bus.seg, exp_seg);
        check("digit", bus.digit, exp_dig);
        check("dp", bus.dp, exp_dp);
        check("page_out", bus.page_out, m_page);
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_seg", bus.seg, 7'b1000000);
        check("rst_digit", bus.digit, 4'b1110);
        check("rst_dp", bus.dp, 1'b1);
        check("rst_page", bus.page_out, 1'b0);
        bus.value_valid = 1'b0;
        bus.page_btn    = 1'b0;
        m_snap  = '0;
        m_page  = 1'b0;
        m_state = 1'b0;
        k       = 0;
        hist.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    int run;

    initial begin
        bus.value_in    = '0;
        bus.value_valid = 1'b0;
        bus.page_btn    = 1'b0;
        do_reset();
        repeat (8) tick();
        bus.value_in    = 32'h1234ABCD;
        bus.value_valid = 1'b1;
        tick();
        bus.value_valid = 1'b0;
        repeat (20) tick();
        bus.page_btn = 1'b1;
        repeat (12) tick();
        bus.page_btn = 1'b0;
        repeat (24) tick();
        for (int i = 0; i < 40; i++) begin
            bus.page_btn = ((i / 3) % 2 == 0);
            tick();
        end
        bus.page_btn = 1'b0;
        repeat (16) tick();
        bus.value_in = 32'hFFFFFFFF;
        repeat (8) tick();
        bus.value_valid = 1'b1;
        tick();
        bus.value_valid = 1'b0;
        repeat (16) tick();
        bus.page_btn = 1'b1;
        repeat (7) tick();
        do_reset();
        repeat (8) tick();
        run = 0;
        repeat (1500) begin
            bus.value_valid = ($urandom_range(0, 7) == 0);
            bus.value_in    = $urandom;
            if (run == 0) begin
                bus.page_btn = ~bus.page_btn;
                run = $urandom_range(1, 14);
            end
            run--;
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
                run = 0;
            end
            tick();
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
